// File: rtl/mux2t1_64_arbiter.sv
// ============================================================================
//  Module   : mux2t1_64_arbiter
//  Function : Round-robin packet arbiter steering a shared 2:1 64-bit mux
//             onto one registered valid/ready output stream.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux2t1_64_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    input  logic         a_last,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    input  logic         b_last,
    output logic         b_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last,
    input  logic         o_ready,
    output logic         sel,
    output logic         busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOCK_A = 2'd1;
    localparam logic [1:0] S_LOCK_B = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         prio_q, prio_d;
    logic         o_valid_q, o_valid_d;
    logic [W-1:0] o_data_q, o_data_d;
    logic         o_last_q, o_last_d;

    logic         w_gnt_vld;
    logic         w_gnt_b;
    logic         w_can_load;
    logic         w_xfer;
    logic [W-1:0] w_mux_data;
    logic         w_mux_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
        end
    end

    // Grant: a held lock ignores the other side even while the owner stalls
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_b   = 1'b0;
        case (state_q)
            S_LOCK_A: begin
                w_gnt_vld = 1'b1;
                w_gnt_b   = 1'b0;
            end
            S_LOCK_B: begin
                w_gnt_vld = 1'b1;
                w_gnt_b   = 1'b1;
            end
            default: begin
                if (a_valid && b_valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_b   = prio_q;
                end else if (a_valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_b   = 1'b0;
                end else if (b_valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_b   = 1'b1;
                end
            end
        endcase
    end

    assign w_can_load = !o_valid_q || o_ready;
    assign w_mux_data = w_gnt_b ? b_data : a_data;
    assign w_mux_last = w_gnt_b ? b_last : a_last;
    assign w_xfer     = (a_valid && a_ready) || (b_valid && b_ready);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (state_q != S_IDLE && state_q != S_LOCK_A && state_q != S_LOCK_B) begin
            state_d = S_IDLE;
        end else if (w_xfer) begin
            if (w_mux_last) begin
                state_d = S_IDLE;
                prio_d  = ~w_gnt_b;
            end else if (state_q == S_IDLE) begin
                state_d = w_gnt_b ? S_LOCK_B : S_LOCK_A;
            end
        end
    end

    // Output logic
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        if (w_xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = w_mux_data;
            o_last_d  = w_mux_last;
        end else if (o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    assign a_ready = w_gnt_vld && !w_gnt_b && w_can_load && !rst;
    assign b_ready = w_gnt_vld &&  w_gnt_b && w_can_load && !rst;
    assign sel     = !rst && w_gnt_b;
    assign busy    = !rst && (state_q == S_LOCK_A || state_q == S_LOCK_B);

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;

    a_never_both_ready : assert property (@(posedge clk) !(a_ready && b_ready));

endmodule

`default_nettype wire

// File: tb/tb_mux2t1_64_arbiter.sv
// ============================================================================
//  Module   : tb_mux2t1_64_arbiter
//  Function : Directed self-checking bench for mux2t1_64_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux2t1_64_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_last, a_ready;
    logic [63:0] a_data;
    logic        b_valid, b_last, b_ready;
    logic [63:0] b_data;
    logic        o_valid, o_last, o_ready;
    logic [63:0] o_data;
    logic        sel, busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux2t1_64_arbiter #(.W(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_ready (o_ready),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [63:0] exp_d;
        int          a_idx;
        int          b_idx;

        rst = 1'b1; o_ready = 1'b1;
        a_valid = 1'b1; a_data = '0; a_last = 1'b1;
        b_valid = 1'b1; b_data = '0; b_last = 1'b1;
        tick(); tick();
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_sel",     sel,     0);
        check("rst_busy",    busy,    0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data",  o_data,  0);
        check("rst_o_last",  o_last,  0);
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
        tick();

        // Single A beat
        a_valid = 1'b1; a_data = 64'h1111_2222_3333_4444; a_last = 1'b1;
        settle();
        check("t1_a_ready", a_ready, 1);
        check("t1_sel",     sel,     0);
        tick();
        a_valid = 1'b0;
        check("t1_o_valid", o_valid, 1);
        check("t1_o_data",  o_data,  64'h1111_2222_3333_4444);
        check("t1_o_last",  o_last,  1);
        check("t1_busy",    busy,    0);

        // Fresh reset so A is favoured, then alternating single beats
        rst = 1'b1; tick(); rst = 1'b0;
        a_idx = 0; b_idx = 0;
        for (int k = 0; k < 6; k++) begin
            a_valid = 1'b1; a_last = 1'b1; a_data = 64'hA0 + 64'(a_idx);
            b_valid = 1'b1; b_last = 1'b1; b_data = 64'hB0 + 64'(b_idx);
            settle();
            check("t2_sel",     sel,     64'(k % 2));
            check("t2_a_ready", a_ready, 64'((k % 2) == 0));
            check("t2_b_ready", b_ready, 64'((k % 2) == 1));
            exp_d = ((k % 2) == 0) ? 64'hA0 + 64'(a_idx) : 64'hB0 + 64'(b_idx);
            tick();
            check("t2_o_valid", o_valid, 1);
            check("t2_o_data",  o_data,  exp_d);
            if ((k % 2) == 0) a_idx++; else b_idx++;
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // 3-beat A packet with B waiting throughout
        a_valid = 1'b1; a_data = 64'hA3_00; a_last = 1'b0;
        b_valid = 1'b1; b_data = 64'hB3_00; b_last = 1'b1;
        settle();
        check("t3_b0_a_ready", a_ready, 1);
        check("t3_b0_b_ready", b_ready, 0);
        check("t3_b0_busy",    busy,    0);
        tick();
        check("t3_b0_o_data",  o_data,  64'hA3_00);
        check("t3_b0_o_last",  o_last,  0);
        a_data = 64'hA3_01;
        settle();
        check("t3_b1_busy",    busy,    1);
        check("t3_b1_sel",     sel,     0);
        check("t3_b1_b_ready", b_ready, 0);
        tick();
        check("t3_b1_o_data",  o_data,  64'hA3_01);
        a_data = 64'hA3_02; a_last = 1'b1;
        settle();
        check("t3_b2_busy",    busy,    1);
        check("t3_b2_b_ready", b_ready, 0);
        tick();
        check("t3_b2_o_data",  o_data,  64'hA3_02);
        check("t3_b2_o_last",  o_last,  1);
        a_valid = 1'b0;
        settle();
        check("t3_b_sel",      sel,     1);
        check("t3_b_b_ready",  b_ready, 1);
        check("t3_b_busy",     busy,    0);
        tick();
        check("t3_b_o_data",   o_data,  64'hB3_00);
        b_valid = 1'b0;

        // A packet stalls for two cycles while B is valid
        a_valid = 1'b1; a_data = 64'hA4_00; a_last = 1'b0;
        b_valid = 1'b1; b_data = 64'hB4_00; b_last = 1'b1;
        settle();
        check("t4_a_ready", a_ready, 1);
        tick();
        check("t4_o_data0", o_data, 64'hA4_00);
        a_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
            settle();
            check("t4_gap_busy",    busy,    1);
            check("t4_gap_sel",     sel,     0);
            check("t4_gap_b_ready", b_ready, 0);
            tick();
            check("t4_gap_o_valid", o_valid, 0);
        end
        a_valid = 1'b1; a_data = 64'hA4_01; a_last = 1'b1;
        settle();
        check("t4_resume_a_ready", a_ready, 1);
        tick();
        check("t4_o_data1", o_data, 64'hA4_01);
        check("t4_o_last1", o_last, 1);
        a_valid = 1'b0;
        settle();
        check("t4_b_sel", sel, 1);
        tick();
        check("t4_b_o_data", o_data, 64'hB4_00);
        b_valid = 1'b0;

        // Back-pressure for four cycles with both requesters waiting
        o_ready = 1'b0;
        a_valid = 1'b1; a_data = 64'hA5_00; a_last = 1'b1;
        b_valid = 1'b1; b_data = 64'hB5_00; b_last = 1'b1;
        for (int s = 0; s < 4; s++) begin
            settle();
            check("t5_bp_a_ready", a_ready, 0);
            check("t5_bp_b_ready", b_ready, 0);
            check("t5_bp_o_valid", o_valid, 1);
            check("t5_bp_o_data",  o_data,  64'hB4_00);
            tick();
        end
        o_ready = 1'b1;
        settle();
        check("t5_a_ready", a_ready, 1);
        tick();
        check("t5_o_data_a", o_data, 64'hA5_00);
        a_valid = 1'b0;
        settle();
        check("t5_b_ready", b_ready, 1);
        tick();
        check("t5_o_data_b", o_data, 64'hB5_00);
        b_valid = 1'b0;
        tick();
        check("t5_drain_o_valid", o_valid, 0);

        // Point prio at B with an A beat, then reset in the middle of a B packet
        a_valid = 1'b1; a_data = 64'hA6_00; a_last = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 64'hB6_00; b_last = 1'b0;
        settle();
        check("t6_b_ready", b_ready, 1);
        tick();
        check("t6_lock_busy", busy, 1);
        check("t6_lock_sel",  sel,  1);
        b_data = 64'hB6_01;
        rst = 1'b1;
        settle();
        check("t6_rst_b_ready", b_ready, 0);
        check("t6_rst_sel",     sel,     0);
        check("t6_rst_busy",    busy,    0);
        tick();
        check("t6_rst_o_valid", o_valid, 0);
        check("t6_rst_o_data",  o_data,  0);
        rst = 1'b0;
        a_valid = 1'b1; a_data = 64'hA6_10; a_last = 1'b1;
        b_valid = 1'b1; b_data = 64'hB6_10; b_last = 1'b1;
        settle();
        check("t6_post_a_ready", a_ready, 1);
        check("t6_post_b_ready", b_ready, 0);
        check("t6_post_busy",    busy,    0);
        tick();
        check("t6_post_o_data",  o_data,  64'hA6_10);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
